// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop sync, counter debounce and one-cycle press pulses for
// {left,right,down,up}, plus a wrapping press counter. Define BTN_AUTO_REPEAT_EN for hold auto-repeat.
module btn_conditioner #(
    parameter int unsigned DB_CYCLES    = 8,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned REPEAT_DELAY = 50,
    parameter int unsigned REPEAT_RATE  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       right,
    input  logic       left,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse,
    output logic       any_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned NB    = 4;
    localparam int unsigned PCNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Elaboration-time guard against configurations the debounce cannot represent.
    if (DB_CYCLES < 1 || (DB_CYCLES - 1) >= (64'd1 << CNT_W) ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("btn_conditioner: invalid parameter set");
    end

    logic [NB-1:0]     raw_c;
    logic [NB-1:0]     sync1_q;
    logic [NB-1:0]     sync2_q;
    logic [CNT_W-1:0]  cnt_q [NB];
    logic [CNT_W-1:0]  cnt_d [NB];
    logic [NB-1:0]     level_q;
    logic [NB-1:0]     level_d;
    logic [NB-1:0]     press_c;
    logic [NB-1:0]     pulse_q;
    logic [NB-1:0]     pulse_d;
    logic              any_q;
    logic              any_d;
    logic [PCNT_W-1:0] count_q;
    logic [PCNT_W-1:0] count_d;

    assign raw_c = {left, right, down, up};

    // Debounce: level flips only after DB_CYCLES consecutive differing samples.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            cnt_d[i]   = '0;
            level_d[i] = level_q[i];
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press_c = level_d & ~level_q;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned HOLD_W = 16;
    localparam logic [HOLD_W-1:0] REP_FIRST = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] REP_NEXT  = HOLD_W'(REPEAT_DELAY + REPEAT_RATE);

    logic [HOLD_W-1:0] hold_q [NB];
    logic [HOLD_W-1:0] hold_d [NB];
    logic [NB-1:0]     rep_c;

    // Hold counter folds back to REP_FIRST after each periodic repeat so it never overflows.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            hold_d[i] = '0;
            rep_c[i]  = 1'b0;
            if (level_q[i] && level_d[i]) begin
                hold_d[i] = hold_q[i] + HOLD_W'(1);
                if (hold_d[i] == REP_FIRST) begin
                    rep_c[i] = 1'b1;
                end else if (hold_d[i] == REP_NEXT) begin
                    rep_c[i]  = 1'b1;
                    hold_d[i] = REP_FIRST;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign pulse_d = press_c | rep_c;
`else
    assign pulse_d = press_c;
`endif

    always_comb begin
        any_d   = |pulse_d;
        count_d = count_q;
        for (int i = 0; i < NB; i++) begin
            count_d = count_d + PCNT_W'(pulse_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            any_q   <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            any_q   <= any_d;
            count_q <= count_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_pulse   = pulse_q;
    assign any_pulse   = any_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: each stimulus pushes the expected pulse (cycle, mask,
// running count) and a negedge monitor pops and compares whenever the DUT pulses.
module tb_btn_conditioner;

    localparam int unsigned DB  = 8;
    localparam int unsigned LAT = DB + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       up, down, right, left;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;
    logic       any_pulse;
    logic [7:0] press_count;

    btn_conditioner dut (
        .clk         (clk),
        .rst         (rst),
        .up          (up),
        .down        (down),
        .right       (right),
        .left        (left),
        .btn_level   (btn_level),
        .btn_pulse   (btn_pulse),
        .any_pulse   (any_pulse),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        logic [3:0]  mask;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_count = '0;
    int          right_seen = 0;
    int unsigned p;
    int unsigned q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [3:0] mask, input int unsigned at);
        exp_count = exp_count + 8'($countones(mask));
        sb_q.push_back('{at, mask, exp_count});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_count = '0;
        tick(2);
    endtask

    // Monitor: every pulse must match the oldest expectation; no pulse means any_pulse low.
    always @(negedge clk) begin
        if (!rst) begin
            if (btn_pulse != 4'b0) begin
                if (btn_pulse[2]) right_seen++;
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", 32'(btn_pulse), 32'h0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("pulse_cycle", mon_e.at, cyc);
                    check("pulse_mask", 32'(btn_pulse), 32'(mon_e.mask));
                    check("any_pulse", 32'(any_pulse), 32'h1);
                    check("press_count", 32'(press_count), 32'(mon_e.cnt));
                end
            end else begin
                check("any_idle", 32'(any_pulse), 32'h0);
            end
        end
    end

    initial begin
        rst = 1'b1; up = 1'b0; down = 1'b0; right = 1'b0; left = 1'b0;
        tick(3);
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_pulse", 32'(btn_pulse), 32'h0);
        check("rst_any", 32'(any_pulse), 32'h0);
        check("rst_count", 32'(press_count), 32'h0);
        rst = 1'b0;
        tick(2);

        // Clean press of up: level rises exactly LAT edges after the input changes.
        up = 1'b1; p = cyc; expect_pulse(4'b0001, p + LAT);
        tick(LAT - 1);
        check("lvl_before_rise", 32'(btn_level), 32'h0);
        tick(1);
        check("lvl_rise", 32'(btn_level), 32'h1);
        tick(1);
        check("pulse_one_cycle", 32'(btn_pulse), 32'h0);
        tick(3);
        up = 1'b0; p = cyc;
        tick(LAT - 1);
        check("lvl_before_fall", 32'(btn_level), 32'h1);
        tick(1);
        check("lvl_fall", 32'(btn_level), 32'h0);
        tick(4);

        // Bounce: 3-cycle highs never qualify; only the final sustained rise pulses.
        for (int k = 0; k < 4; k++) begin
            up = (k % 2 == 0);
            tick(3);
        end
        up = 1'b1; p = cyc; expect_pulse(4'b0001, p + LAT);
        tick(LAT + 3);
        up = 1'b0;
        tick(LAT + 3);
        check("bounce_count", 32'(press_count), 32'h2);

        // Simultaneous down + left.
        down = 1'b1; left = 1'b1; p = cyc; expect_pulse(4'b1010, p + LAT);
        tick(LAT + 3);
        check("simul_level", 32'(btn_level), 32'hA);
        check("simul_count", 32'(press_count), 32'h4);
        down = 1'b0; left = 1'b0;
        tick(LAT + 3);

        // Glitch of DB-1 cycles is rejected; exactly DB cycles is accepted.
        right = 1'b1;
        tick(DB - 1);
        right = 1'b0;
        tick(LAT + 3);
        check("glitch_level", 32'(btn_level), 32'h0);
        right = 1'b1; p = cyc; expect_pulse(4'b0100, p + LAT);
        tick(DB);
        right = 1'b0;
        tick(LAT + 3);
        check("min_press_level", 32'(btn_level), 32'h0);

        // 256 presses wrap the counter back to zero.
        do_reset();
        right_seen = 0;
        for (int k = 0; k < 256; k++) begin
            right = 1'b1; p = cyc; expect_pulse(4'b0100, p + LAT);
            tick(LAT + 2);
            right = 1'b0;
            tick(LAT + 2);
        end
        check("wrap_count", 32'(press_count), 32'h0);
        check("wrap_seen", 32'(right_seen), 32'd256);

        // Reset while up is mid-debounce (cnt=5), released while still held.
        up = 1'b1;
        tick(7);
        rst = 1'b1;
        tick(1);
        check("midrst_level", 32'(btn_level), 32'h0);
        check("midrst_count", 32'(press_count), 32'h0);
        tick(2);
        check("midrst_pulse", 32'(btn_pulse), 32'h0);
        check("midrst_any", 32'(any_pulse), 32'h0);
        rst = 1'b0; exp_count = '0; p = cyc; expect_pulse(4'b0001, p + LAT);
        tick(LAT + 2);
        check("midrst_after", 32'(press_count), 32'h1);
        up = 1'b0;
        tick(LAT + 3);

        // Long hold: release timed so the level drops between the +100 and +110 slots.
        do_reset();
        up = 1'b1; p = cyc; q = p + LAT; expect_pulse(4'b0001, q);
`ifdef BTN_AUTO_REPEAT_EN
        for (int k = 0; k < 6; k++) begin
            expect_pulse(4'b0001, q + 50 + 10 * k);
        end
`endif
        tick(LAT + 95);
        up = 1'b0;
        tick(LAT + 20);
`ifdef BTN_AUTO_REPEAT_EN
        check("hold_count", 32'(press_count), 32'd7);
`else
        check("hold_count", 32'(press_count), 32'd1);
`endif

        tick(5);
        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the four raw board pushbuttons (up, down, right, left) before they reach game_logic.
- Per button: 2-flop synchronizer, counter-based debounce, one-cycle press pulse.
- Also keeps a running press counter.
- Clocked in the same domain as game_logic (slowest_clk at top level), so its pulses are exactly one game_logic cycle wide.

Parameters:
- DB_CYCLES, 8, consecutive cycles a synchronized input must differ from the stable level before the level flips (must be >= 1).
- CNT_W, 8, width of each debounce counter (must hold DB_CYCLES-1).
- REPEAT_DELAY, 50, cycles from press pulse to first auto-repeat pulse (AUTO_REPEAT_EN only).
- REPEAT_RATE, 10, cycles between subsequent auto-repeat pulses (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  module clock (game_logic domain)
- rst  input  1  synchronous, active-high reset
- up  input  1  raw, asynchronous button
- down  input  1  raw, asynchronous button
- right  input  1  raw, asynchronous button
- left  input  1  raw, asynchronous button
- btn_level  output  4  debounced stable levels, bit order {left,right,down,up} = [3:0]
- btn_pulse  output  4  one-cycle press pulses, same bit order
- any_pulse  output  1  OR of btn_pulse
- press_count  output  8  total accepted presses, wraps modulo 256

Behaviour:
- All outputs are registered.
- Reset: one synchronous, active-high reset on clk. While rst=1 at a clk edge, the following are all cleared to 0 at that edge: sync flops, debounce counters, btn_level, btn_pulse, any_pulse, press_count, repeat counters. rst has priority over all other updates.
- Synchronizer: sync1<=raw, sync2<=sync1. Only sync2 feeds the debounce logic.
- Debounce, per bit, at each edge:
  - sync2==btn_level: cnt<=0.
  - sync2!=btn_level and cnt<DB_CYCLES-1: cnt<=cnt+1.
  - sync2!=btn_level and cnt==DB_CYCLES-1: btn_level<=sync2, cnt<=0.
- Any bounce back to the stable value restarts the count from 0. There is no partial credit.
- Latency: raw rises and is held from before edge 0. btn_level and btn_pulse go high after edge DB_CYCLES+1. Release obeys the same latency for btn_level.
- Pulse: btn_pulse[i]<=1 at the edge where btn_level[i] flips 0->1, otherwise 0. Width is exactly 1 cycle.
- Release (1->0 flip) never produces a pulse.
- any_pulse is registered alongside btn_pulse, with identical timing.
- press_count increments at each edge by popcount(next btn_pulse), i.e. 0..4 in one cycle. It wraps 255->0 (or further when several pulses coincide).
- Simultaneous buttons: bits are fully independent. Two buttons reaching threshold on the same edge give two pulse bits in the same cycle and press_count+2.
- Reset mid-debounce: a partial count is discarded.
- Button held across reset release: btn_level restarts at 0, so the held button is re-debounced and produces a fresh pulse DB_CYCLES+2 edges after the first non-reset edge (2 sync stages + DB_CYCLES).
- Glitch shorter than DB_CYCLES cycles (after sync): no change to btn_level, btn_pulse or press_count.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - Each bit has a 16-bit hold counter. It clears on the press pulse and counts while btn_level=1.
  - Additional pulse when the counter reaches REPEAT_DELAY, then every REPEAT_RATE cycles after that, while the button stays held.
  - Each repeat pulse is also counted in press_count.
  - Release (btn_level 1->0) or rst clears the counter immediately. No pulse is issued on the release edge.
- Undefined: exactly one pulse per debounced press, and no hold counters are synthesized.

Test Plan:
- Reset, DB_CYCLES=8: hold up=1 from edge 0 -> btn_level[0] and btn_pulse[0] rise after edge 9; pulse low after edge 10; press_count=1; any_pulse matches.
- Bounce: up toggles 1,0,1,0 every 3 cycles, then holds 1 -> exactly one pulse, 8 cycles after the final rise passes sync2; press_count=1.
- Simultaneous: down and left rise on the same edge -> btn_pulse=4'b1010 for one cycle; press_count 0->2.
- Wrap: 256 clean presses of right -> press_count returns to 0; btn_pulse[2] seen 256 times.
- Reset mid-operation: rst=1 at cnt=5 with up held, deassert while still held -> all outputs 0 during reset; pulse appears 10 edges after the first non-reset edge (2 sync + 8 debounce); press_count=1.
- BTN_AUTO_REPEAT_EN, REPEAT_DELAY=50, REPEAT_RATE=10: hold up for 100 cycles past the press pulse -> pulses at +0, +50, +60, +70, +80, +90, +100; release -> no further pulses; press_count=7.
